// File: rtl/pattern_multi_snake.sv
// pattern_multi_snake
//   Framebuffer pattern generator for a chain of MAX7219 8x8 matrices.
//   NUM_SNAKES independent diagonal heads move over a FB_WIDTH x FB_HEIGHT
//   pixel grid, painting the pixel under each head once per step in the
//   selected draw mode, then advancing with bounce or wrap-around edges.
//   All state advances on the falling edge of i_Clk.
//
//   Stream map: data word [w][r][c] carries pixel row y = r*8 + (7-w) of
//   matrix (r,c), so word 7 holds the bottom row y = 0. Its low byte has
//   bit i = pixel x = c*8 + i, and its digit register is 8-w.
//
//   Optional build macro PATTERN_SNAKE_COLLISION_CNT_EN adds o_Collisions, a
//   saturating count of paint events that landed on an already lit pixel.
module pattern_multi_snake #(
    parameter int DISP_ROWS    = 1,
    parameter int DISP_COLUMNS = 1,
    parameter int NUM_SNAKES   = 2,
    parameter int DELAY_CLOCKS = 60000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [1:0]  i_Mode,
    input  logic        i_Wrap,
    input  logic        i_Pause,
    input  logic        i_Clear,
    output logic        o_Step,
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
    output logic [15:0] o_Collisions,
`endif
    output logic [0:7][DISP_ROWS-1:0][DISP_COLUMNS-1:0][15:0] o_MAX7219_DataStream
);

    localparam int FB_WIDTH  = 8 * DISP_COLUMNS;
    localparam int FB_HEIGHT = 8 * DISP_ROWS;
    localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;
    localparam int XW        = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
    localparam int YW        = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;
    localparam int CW        = $clog2(DELAY_CLOCKS + 1);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_SET    = 2'd1,
        MODE_CLEAR  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [FB_SIZE-1:0]     fb_q;
    logic [XW-1:0]          x_q      [NUM_SNAKES];
    logic [YW-1:0]          y_q      [NUM_SNAKES];
    logic [NUM_SNAKES-1:0]  x_dir_q;   // 1 = towards larger x
    logic [NUM_SNAKES-1:0]  y_dir_q;   // 1 = towards larger y

    logic [FB_SIZE-1:0]     toggle_mask;
    logic [FB_SIZE-1:0]     hit_mask;
    logic [FB_SIZE-1:0]     fb_next;
    logic [NUM_SNAKES-1:0]  lit;
    logic [XW-1:0]          x_next   [NUM_SNAKES];
    logic [YW-1:0]          y_next   [NUM_SNAKES];
    logic [NUM_SNAKES-1:0]  x_dir_next;
    logic [NUM_SNAKES-1:0]  y_dir_next;

    // Head k starts evenly spaced along the bottom row.
    function automatic logic [XW-1:0] start_x(input int k);
        return XW'((k * FB_WIDTH) / NUM_SNAKES);
    endfunction

    // Next coordinate on one axis. Bounce reflects at either edge whatever
    // the current direction; wrap treats the axis as a ring.
    function automatic int adv_coord(input int c, input int size, input logic dir, input logic wrap);
        if (wrap) begin
            if (dir) return (c == size - 1) ? 0 : c + 1;
            return (c == 0) ? size - 1 : c - 1;
        end
        if (c == size - 1) return c - 1;
        if (c == 0) return c + 1;
        return dir ? c + 1 : c - 1;
    endfunction

    function automatic logic adv_dir(input int c, input int size, input logic dir, input logic wrap);
        if (wrap) return dir;
        if (c == size - 1) return 1'b0;
        if (c == 0) return 1'b1;
        return dir;
    endfunction

    // Paint masks from the pre-step snapshot: toggle counts hit parity, set/clear only need "hit at all".
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch can be inferred.
        toggle_mask = '0;
        hit_mask    = '0;
        lit         = '0;
        for (int k = 0; k < NUM_SNAKES; k++) begin
            toggle_mask[int'(y_q[k]) * FB_WIDTH + int'(x_q[k])] =
                ~toggle_mask[int'(y_q[k]) * FB_WIDTH + int'(x_q[k])];
            hit_mask[int'(y_q[k]) * FB_WIDTH + int'(x_q[k])] = 1'b1;
            lit[k] = fb_q[int'(y_q[k]) * FB_WIDTH + int'(x_q[k])];
        end
        case (mode_e'(i_Mode))
            MODE_SET:   fb_next = fb_q | hit_mask;
            MODE_CLEAR: fb_next = fb_q & ~hit_mask;
            default:    fb_next = fb_q ^ toggle_mask;
        endcase
    end

    // Next head positions and directions, each axis handled independently.
    always_comb begin
        for (int k = 0; k < NUM_SNAKES; k++) begin
            x_next[k]     = XW'(adv_coord(int'(x_q[k]), FB_WIDTH,  x_dir_q[k], i_Wrap));
            y_next[k]     = YW'(adv_coord(int'(y_q[k]), FB_HEIGHT, y_dir_q[k], i_Wrap));
            x_dir_next[k] = adv_dir(int'(x_q[k]), FB_WIDTH,  x_dir_q[k], i_Wrap);
            y_dir_next[k] = adv_dir(int'(y_q[k]), FB_HEIGHT, y_dir_q[k], i_Wrap);
        end
    end

`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
    logic [15:0] coll_q;
    logic [15:0] coll_next;

    // Saturating add of this step's collisions.
    always_comb begin
        int sum;
        sum       = int'(coll_q) + $countones(lit);
        coll_next = (sum > 65535) ? 16'hFFFF : 16'(sum);
    end

    assign o_Collisions = coll_q;
`endif

    // Step sequencer: WAIT counts the delay, STEP paints and moves, CLEAR restarts.
    always_ff @(negedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            o_Step  <= 1'b0;
            // NOTE: the framebuffer is plain flops rather than a RAM, so it can be cleared by the async reset.
            fb_q    <= '0;
            for (int k = 0; k < NUM_SNAKES; k++) begin
                x_q[k]     <= start_x(k);
                y_q[k]     <= '0;
                x_dir_q[k] <= ((k % 2) == 0);
                y_dir_q[k] <= 1'b1;
            end
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
            coll_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register sees the same pre-edge values.
            o_Step <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (!i_Pause) begin
                        if (cnt_q == CW'(DELAY_CLOCKS - 1)) begin
                            cnt_q   <= '0;
                            state_q <= ST_STEP;
                            o_Step  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    state_q <= i_Clear ? ST_CLEAR : ST_WAIT;
                    if (!i_Clear) begin
                        fb_q    <= fb_next;
                        x_q     <= x_next;
                        y_q     <= y_next;
                        x_dir_q <= x_dir_next;
                        y_dir_q <= y_dir_next;
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
                        coll_q  <= coll_next;
`endif
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_WAIT;
                    fb_q    <= '0;
                    for (int k = 0; k < NUM_SNAKES; k++) begin
                        x_q[k]     <= start_x(k);
                        y_q[k]     <= '0;
                        x_dir_q[k] <= ((k % 2) == 0);
                        y_dir_q[k] <= 1'b1;
                    end
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
                    coll_q  <= '0;
`endif
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    // Display words: digit register plus one matrix row, straight from the framebuffer.
    for (genvar w = 0; w < 8; w++) begin : g_word
        for (genvar r = 0; r < DISP_ROWS; r++) begin : g_row
            for (genvar c = 0; c < DISP_COLUMNS; c++) begin : g_col
                assign o_MAX7219_DataStream[w][r][c] =
                    {4'h0, 4'(8 - w), fb_q[(r * 8 + 7 - w) * FB_WIDTH + c * 8 +: 8]};
            end
        end
    end

endmodule

// File: tb/tb_pattern_multi_snake.sv
// tb_pattern_multi_snake
//   Directed bench: one single-head instance (dut_a) and one two-head
//   instance (dut_b), both 1x1 matrix with a 2-clock step delay.
//   DUT state moves on the falling edge; the bench drives and samples just
//   after the rising edge.
module tb_pattern_multi_snake;

    localparam int DLY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_wrap, a_pause, a_clear, a_step;
    logic [1:0] a_mode;
    logic [0:7][0:0][0:0][15:0] a_stream;
    logic       b_rst, b_wrap, b_pause, b_clear, b_step;
    logic [1:0] b_mode;
    logic [0:7][0:0][0:0][15:0] b_stream;
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
    logic [15:0] a_coll, b_coll;
`endif

    pattern_multi_snake #(
        .DISP_ROWS(1), .DISP_COLUMNS(1), .NUM_SNAKES(1), .DELAY_CLOCKS(DLY)
    ) dut_a (
        .i_Clk(clk), .i_Rst(a_rst), .i_Mode(a_mode), .i_Wrap(a_wrap),
        .i_Pause(a_pause), .i_Clear(a_clear), .o_Step(a_step),
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        .o_Collisions(a_coll),
`endif
        .o_MAX7219_DataStream(a_stream)
    );

    pattern_multi_snake #(
        .DISP_ROWS(1), .DISP_COLUMNS(1), .NUM_SNAKES(2), .DELAY_CLOCKS(DLY)
    ) dut_b (
        .i_Clk(clk), .i_Rst(b_rst), .i_Mode(b_mode), .i_Wrap(b_wrap),
        .i_Pause(b_pause), .i_Clear(b_clear), .o_Step(b_step),
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        .o_Collisions(b_coll),
`endif
        .o_MAX7219_DataStream(b_stream)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel row y of a single-matrix stream (word 7 is row 0).
    function automatic logic [7:0] row_a(input int y);
        return a_stream[7 - y][0][0][7:0];
    endfunction

    function automatic logic [7:0] row_b(input int y);
        return b_stream[7 - y][0][0][7:0];
    endfunction

    // Waits for the next rising edge that sees o_Step high; cyc = edges waited.
    task automatic wait_pulse(input bit sel_b, output int cyc);
        logic s;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            s = sel_b ? b_step : a_step;
        end while (s !== 1'b1 && cyc < 50);
        check(sel_b ? "step_seen_b" : "step_seen_a", {31'b0, s}, 32'd1);
    endtask

    // n steps, then one more edge so the last paint is visible.
    task automatic run(input bit sel_b, input int n);
        int c;
        repeat (n) wait_pulse(sel_b, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int np;
        a_rst = 1'b1; a_mode = 2'd0; a_wrap = 1'b0; a_pause = 1'b0; a_clear = 1'b0;
        b_rst = 1'b1; b_mode = 2'd0; b_wrap = 1'b0; b_pause = 1'b0; b_clear = 1'b0;
        #22;

        // Reset state
        check("rst_step", {31'b0, a_step}, 32'd0);
        for (int y = 0; y < 8; y++) check("rst_row_a", {24'b0, row_a(y)}, 32'd0);
        check("hdr_word7", {24'b0, a_stream[7][0][0][15:8]}, 32'h01);
        check("hdr_word0", {24'b0, a_stream[0][0][0][15:8]}, 32'h08);
        check("rst_head_a_x", {29'b0, dut_a.x_q[0]}, 32'd0);
        check("rst_head_b1_x", {29'b0, dut_b.x_q[1]}, 32'd4);
        check("rst_dir_b0", {31'b0, dut_b.x_dir_q[0]}, 32'd1);
        check("rst_dir_b1", {31'b0, dut_b.x_dir_q[1]}, 32'd0);

        // Single head, toggle, bounce: step cadence and first three pixels
        @(posedge clk);
        a_rst = 1'b0;
        wait_pulse(1'b0, c);
        check("first_step_latency", c, 32'd2);
        wait_pulse(1'b0, c);
        check("step_period_1", c, 32'd3);
        wait_pulse(1'b0, c);
        check("step_period_2", c, 32'd3);
        @(posedge clk);
        #1;
        check("t1_row0", {24'b0, row_a(0)}, 32'h01);
        check("t1_row1", {24'b0, row_a(1)}, 32'h02);
        check("t1_row2", {24'b0, row_a(2)}, 32'h04);
        check("t1_row3", {24'b0, row_a(3)}, 32'h00);
        check("t1_head_x", {29'b0, dut_a.x_q[0]}, 32'd3);
        check("t1_head_y", {29'b0, dut_a.y_q[0]}, 32'd3);

        // Bounce at the far corner
        run(1'b0, 5);
        check("t2_s8_row7", {24'b0, row_a(7)}, 32'h80);
        check("t2_s8_row6", {24'b0, row_a(6)}, 32'h40);
        check("t2_s8_head_x", {29'b0, dut_a.x_q[0]}, 32'd6);
        check("t2_s8_dir_x", {31'b0, dut_a.x_dir_q[0]}, 32'd0);
        run(1'b0, 1);
        check("t2_s9_row6", {24'b0, row_a(6)}, 32'h00);
        run(1'b0, 6);
        check("t2_s15_row0", {24'b0, row_a(0)}, 32'h00);
        check("t2_s15_row5", {24'b0, row_a(5)}, 32'h00);
        check("t2_s15_row7", {24'b0, row_a(7)}, 32'h80);
        check("t2_s15_head_y", {29'b0, dut_a.y_q[0]}, 32'd1);
        check("t2_s15_dir_y", {31'b0, dut_a.y_dir_q[0]}, 32'd1);
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        check("coll_bounce15", {16'b0, a_coll}, 32'd7);
`endif

        // Asynchronous reset in the middle of a STEP cycle
        wait_pulse(1'b0, c);
        #2;
        a_rst = 1'b1;
        #1;
        check("async_rst_step", {31'b0, a_step}, 32'd0);
        check("async_rst_row7", {24'b0, row_a(7)}, 32'h00);
        check("async_rst_head_y", {29'b0, dut_a.y_q[0]}, 32'd0);
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        check("async_rst_coll", {16'b0, a_coll}, 32'd0);
`endif

        // Wrap mode: full diagonal after 8 steps, then (0,0) toggles off
        @(posedge clk);
        a_wrap = 1'b1;
        a_rst  = 1'b0;
        run(1'b0, 8);
        check("t3_row0", {24'b0, row_a(0)}, 32'h01);
        check("t3_row3", {24'b0, row_a(3)}, 32'h08);
        check("t3_row7", {24'b0, row_a(7)}, 32'h80);
        check("t3_head_x", {29'b0, dut_a.x_q[0]}, 32'd0);
        check("t3_head_y", {29'b0, dut_a.y_q[0]}, 32'd0);
        check("t3_dir_x", {31'b0, dut_a.x_dir_q[0]}, 32'd1);
        run(1'b0, 1);
        check("t3_s9_row0", {24'b0, row_a(0)}, 32'h00);
        check("t3_s9_row1", {24'b0, row_a(1)}, 32'h02);
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        check("coll_wrap9", {16'b0, a_coll}, 32'd1);
`endif

        // Clear: the STEP that sees i_Clear paints nothing, CLEAR follows
        a_clear = 1'b1;
        wait_pulse(1'b0, c);
        @(posedge clk);
        #1;
        check("clr_state", {30'b0, dut_a.state_q}, 32'd2);
        check("clr_no_pulse", {31'b0, a_step}, 32'd0);
        check("clr_no_paint_row1", {24'b0, row_a(1)}, 32'h02);
        a_clear = 1'b0;
        @(posedge clk);
        #1;
        check("clr_row1", {24'b0, row_a(1)}, 32'h00);
        check("clr_row7", {24'b0, row_a(7)}, 32'h00);
        check("clr_head_x", {29'b0, dut_a.x_q[0]}, 32'd0);
        check("clr_head_y", {29'b0, dut_a.y_q[0]}, 32'd0);
`ifdef PATTERN_SNAKE_COLLISION_CNT_EN
        check("clr_coll", {16'b0, a_coll}, 32'd0);
`endif

        // Pause: no steps and a frozen picture; two WAIT clocks remain after release
        run(1'b0, 2);
        a_pause = 1'b1;
        np = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (a_step === 1'b1) np++;
        end
        check("pause_no_step", np, 32'd0);
        check("pause_row0", {24'b0, row_a(0)}, 32'h01);
        check("pause_row1", {24'b0, row_a(1)}, 32'h02);
        a_pause = 1'b0;
        wait_pulse(1'b0, c);
        check("resume_latency", c, 32'd2);
        @(posedge clk);
        #1;
        check("resume_row2", {24'b0, row_a(2)}, 32'h04);

        // Two heads, toggle: both land on (2,2) in step 3 and cancel
        @(posedge clk);
        b_rst = 1'b0;
        run(1'b1, 3);
        check("t4_tog_row0", {24'b0, row_b(0)}, 32'h11);
        check("t4_tog_row1", {24'b0, row_b(1)}, 32'h0A);
        check("t4_tog_row2", {24'b0, row_b(2)}, 32'h00);
        check("t4_head0_x", {29'b0, dut_b.x_q[0]}, 32'd3);
        check("t4_head1_x", {29'b0, dut_b.x_q[1]}, 32'd1);

        // Same stimulus in set mode: the double hit leaves the pixel lit
        b_rst = 1'b1;
        @(posedge clk);
        b_mode = 2'd1;
        b_rst  = 1'b0;
        run(1'b1, 3);
        check("t4_set_row0", {24'b0, row_b(0)}, 32'h11);
        check("t4_set_row2", {24'b0, row_b(2)}, 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
